// File: rtl/soc_mem_bank_burst.sv
// Wishbone B3 memory bank built from per-byte-lane synchronous RAMs; classic cycles ack after one wait state,
// incrementing/wrapping bursts ack every strobed beat after the first; stb low in a burst stalls without loss.
module soc_mem_bank_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 14
) (
    input  logic                    mem_clk_i,
    input  logic                    mem_rst_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    output logic [DATA_WIDTH-1:0]   mem_data_o,
    input  logic [31:0]             mem_addr_i,
    input  logic [DATA_WIDTH/8-1:0] mem_sel_i,
    input  logic                    mem_we_i,
    input  logic                    mem_cyc_i,
    input  logic                    mem_stb_i,
    input  logic [2:0]              mem_cti_i,
    input  logic [1:0]              mem_bte_i,
    output logic                    mem_ack_o,
    output logic                    mem_err_o,
    output logic                    mem_rty_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int AB    = $clog2(NB);
    localparam int WORDS = 1 << MEM_DEPTH;

    localparam logic [2:0] CTI_INC = 3'b010;
    localparam logic [2:0] CTI_EOB = 3'b111;
    localparam logic [1:0] BTE_LIN = 2'b00;
    localparam logic [1:0] BTE_W4  = 2'b01;
    localparam logic [1:0] BTE_W8  = 2'b10;
    localparam logic [1:0] BTE_W16 = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_BURST, S_ERR} state_t;

    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [MEM_DEPTH-1:0] waddr_q, waddr_d;

    logic [MEM_DEPTH-1:0] req_idx;
    logic [MEM_DEPTH-1:0] rd_addr;
    logic [MEM_DEPTH-1:0] wrap_mask;
    logic [MEM_DEPTH-1:0] waddr_inc;
    logic [MEM_DEPTH-1:0] waddr_nxt;
    logic                 req_oor;
    logic                 beat;
    logic                 top_hit;
    logic                 wr_en;
    logic                 addr_lsb_unused;

    assign req_idx         = mem_addr_i[MEM_DEPTH+AB-1:AB];
    assign req_oor         = |mem_addr_i[31:MEM_DEPTH+AB];
    assign addr_lsb_unused = ^mem_addr_i;

    assign mem_ack_o = ack_q & mem_cyc_i & mem_stb_i;
    assign mem_err_o = err_q & mem_cyc_i & mem_stb_i;
    assign mem_rty_o = 1'b0;

    assign beat  = mem_ack_o;
    assign wr_en = mem_ack_o & mem_we_i;

    always_comb begin
        wrap_mask = '1;
        case (mem_bte_i)
            BTE_W4:  wrap_mask = MEM_DEPTH'(4'h3);
            BTE_W8:  wrap_mask = MEM_DEPTH'(4'h7);
            BTE_W16: wrap_mask = MEM_DEPTH'(4'hF);
            default: wrap_mask = '1;
        endcase
    end

    // Wrapping bursts only count inside the mask; upper bits stay put.
    assign waddr_inc = waddr_q + MEM_DEPTH'(1);
    assign waddr_nxt = (waddr_q & ~wrap_mask) | (waddr_inc & wrap_mask);
    assign top_hit   = (mem_bte_i == BTE_LIN) && (&waddr_q);

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        err_d   = err_q;
        waddr_d = waddr_q;
        rd_addr = waddr_q;
        if (!mem_cyc_i) begin
            state_d = S_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rd_addr = req_idx;
                    if (mem_stb_i) begin
                        if (req_oor) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_ACK;
                            ack_d   = 1'b1;
                            waddr_d = req_idx;
                        end
                    end
                end
                S_ACK: begin
                    if (beat) begin
                        if (mem_cti_i == CTI_INC) begin
                            if (top_hit) begin
                                state_d = S_ERR;
                                ack_d   = 1'b0;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_BURST;
                                waddr_d = waddr_nxt;
                                rd_addr = waddr_nxt;
                            end
                        end else begin
                            state_d = S_IDLE;
                            ack_d   = 1'b0;
                        end
                    end
                end
                S_BURST: begin
                    if (beat) begin
                        if (mem_cti_i == CTI_EOB) begin
                            state_d = S_IDLE;
                            ack_d   = 1'b0;
                        end else if (top_hit) begin
                            // Linear burst would roll past the last word: the next beat errors.
                            state_d = S_ERR;
                            ack_d   = 1'b0;
                            err_d   = 1'b1;
                        end else begin
                            waddr_d = waddr_nxt;
                            rd_addr = waddr_nxt;
                        end
                    end
                end
                S_ERR: begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge mem_clk_i or posedge mem_rst_i) begin
        if (mem_rst_i) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            waddr_q <= waddr_d;
        end
    end

    // Read register freezes under reset so the output stays stable.
    for (genvar n = 0; n < NB; n++) begin : g_lane
        logic [7:0] ram [WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge mem_clk_i) begin
            if (wr_en && mem_sel_i[n]) begin
                ram[waddr_q] <= mem_data_i[8*n +: 8];
            end
            if (!mem_rst_i) begin
                rd_q <= ram[rd_addr];
            end
        end

        assign mem_data_o[8*n +: 8] = rd_q;
    end

endmodule

// File: tb/tb_soc_mem_bank_burst.sv
// Directed bench for soc_mem_bank_burst: per-cycle vector table plus hand-timed reset sequences.
module tb_soc_mem_bank_burst;
    localparam logic [2:0] CL  = 3'b000;
    localparam logic [2:0] INC = 3'b010;
    localparam logic [2:0] EOB = 3'b111;
    localparam logic [1:0] LIN = 2'b00;
    localparam logic [1:0] W4  = 2'b01;

    logic        clk;
    logic        rst;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, rty;

    int checks = 0;
    int errors = 0;
    int row_n  = 0;

    soc_mem_bank_burst #(.DATA_WIDTH(32), .MEM_DEPTH(14)) dut (
        .mem_clk_i (clk),
        .mem_rst_i (rst),
        .mem_data_i(dat_i),
        .mem_data_o(dat_o),
        .mem_addr_i(addr),
        .mem_sel_i (sel),
        .mem_we_i  (we),
        .mem_cyc_i (cyc),
        .mem_stb_i (stb),
        .mem_cti_i (cti),
        .mem_bte_i (bte),
        .mem_ack_o (ack),
        .mem_err_o (err),
        .mem_rty_o (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cyc, stb, we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] wdat;
        logic        exp_ack, exp_err, chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t w(input logic [31:0] a, input logic [3:0] s, input logic [2:0] c,
                               input logic [1:0] b, input logic [31:0] d, input logic ea, input logic ee);
        vec_t v;
        v.cyc = 1'b1; v.stb = 1'b1; v.we = 1'b1; v.addr = a; v.sel = s; v.cti = c; v.bte = b;
        v.wdat = d; v.exp_ack = ea; v.exp_err = ee; v.chk_dat = 1'b0; v.exp_dat = '0;
        return v;
    endfunction

    function automatic vec_t r(input logic [31:0] a, input logic [2:0] c, input logic [1:0] b,
                               input logic ea, input logic ee, input logic cd, input logic [31:0] ed);
        vec_t v;
        v.cyc = 1'b1; v.stb = 1'b1; v.we = 1'b0; v.addr = a; v.sel = 4'hF; v.cti = c; v.bte = b;
        v.wdat = '0; v.exp_ack = ea; v.exp_err = ee; v.chk_dat = cd; v.exp_dat = ed;
        return v;
    endfunction

    function automatic vec_t idle_v();
        vec_t v;
        v.cyc = 1'b0; v.stb = 1'b0; v.we = 1'b0; v.addr = '0; v.sel = '0; v.cti = CL; v.bte = LIN;
        v.wdat = '0; v.exp_ack = 1'b0; v.exp_err = 1'b0; v.chk_dat = 1'b0; v.exp_dat = '0;
        return v;
    endfunction

    function automatic vec_t hold_v();
        vec_t v;
        v = idle_v();
        v.cyc = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cyc = v.cyc; stb = v.stb; we = v.we; addr = v.addr; sel = v.sel;
        cti = v.cti; bte = v.bte; dat_i = v.wdat;
    endtask

    task automatic run_row(input vec_t v);
        drive(v);
        @(negedge clk);
        chk($sformatf("row%0d ack", row_n), 32'(ack), 32'(v.exp_ack));
        chk($sformatf("row%0d err", row_n), 32'(err), 32'(v.exp_err));
        chk($sformatf("row%0d rty", row_n), 32'(rty), 32'h0);
        if (v.chk_dat) chk($sformatf("row%0d data", row_n), dat_o, v.exp_dat);
        row_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic classic_wr(input logic [31:0] a, input logic [31:0] d);
        run_row(w(a, 4'hF, CL, LIN, d, 1'b0, 1'b0));
        run_row(w(a, 4'hF, CL, LIN, d, 1'b1, 1'b0));
        run_row(idle_v());
    endtask

    task automatic classic_rd(input logic [31:0] a, input logic [31:0] exp);
        run_row(r(a, CL, LIN, 1'b0, 1'b0, 1'b0, '0));
        run_row(r(a, CL, LIN, 1'b1, 1'b0, 1'b1, exp));
        run_row(idle_v());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Classic write then read
        tbl.push_back(w(32'h100, 4'hF, CL, LIN, 32'hDEADBEEF, 0, 0));
        tbl.push_back(w(32'h100, 4'hF, CL, LIN, 32'hDEADBEEF, 1, 0));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'h100, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h100, CL, LIN, 1, 0, 1, 32'hDEADBEEF));
        tbl.push_back(idle_v());
        // Single byte lane write
        tbl.push_back(w(32'h100, 4'h2, CL, LIN, 32'hFFFF55FF, 0, 0));
        tbl.push_back(w(32'h100, 4'h2, CL, LIN, 32'hFFFF55FF, 1, 0));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'h100, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h100, CL, LIN, 1, 0, 1, 32'hDEAD55EF));
        tbl.push_back(idle_v());
        // Linear burst write / read at 0x200
        tbl.push_back(w(32'h200, 4'hF, INC, LIN, 32'h11, 0, 0));
        tbl.push_back(w(32'h200, 4'hF, INC, LIN, 32'h11, 1, 0));
        tbl.push_back(w(32'h204, 4'hF, INC, LIN, 32'h22, 1, 0));
        tbl.push_back(w(32'h208, 4'hF, INC, LIN, 32'h33, 1, 0));
        tbl.push_back(w(32'h20C, 4'hF, EOB, LIN, 32'h44, 1, 0));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'h200, INC, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h200, INC, LIN, 1, 0, 1, 32'h11));
        tbl.push_back(r(32'h204, INC, LIN, 1, 0, 1, 32'h22));
        tbl.push_back(r(32'h208, INC, LIN, 1, 0, 1, 32'h33));
        tbl.push_back(r(32'h20C, EOB, LIN, 1, 0, 1, 32'h44));
        tbl.push_back(r(32'h204, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h204, CL, LIN, 1, 0, 1, 32'h22));
        tbl.push_back(idle_v());
        // Wrap-4 read from 0x208 with a stalled beat
        tbl.push_back(r(32'h208, INC, W4, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h208, INC, W4, 1, 0, 1, 32'h33));
        tbl.push_back(r(32'h20C, INC, W4, 1, 0, 1, 32'h44));
        tbl.push_back(hold_v());
        tbl.push_back(r(32'h200, INC, W4, 1, 0, 1, 32'h11));
        tbl.push_back(r(32'h204, EOB, W4, 1, 0, 1, 32'h22));
        tbl.push_back(idle_v());
        // Out-of-range access leaves word 0 alone
        tbl.push_back(w(32'h0, 4'hF, CL, LIN, 32'h12345678, 0, 0));
        tbl.push_back(w(32'h0, 4'hF, CL, LIN, 32'h12345678, 1, 0));
        tbl.push_back(idle_v());
        tbl.push_back(w(32'h00010000, 4'hF, CL, LIN, 32'hBAD0BAD0, 0, 0));
        tbl.push_back(w(32'h00010000, 4'hF, CL, LIN, 32'hBAD0BAD0, 0, 1));
        tbl.push_back(w(32'h00010000, 4'hF, CL, LIN, 32'hBAD0BAD0, 0, 0));
        tbl.push_back(idle_v());
        tbl.push_back(idle_v());
        tbl.push_back(r(32'h0, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h0, CL, LIN, 1, 0, 1, 32'h12345678));
        tbl.push_back(idle_v());
        // Linear burst running off the top of memory
        tbl.push_back(w(32'hFFF8, 4'hF, INC, LIN, 32'hA1A1A1A1, 0, 0));
        tbl.push_back(w(32'hFFF8, 4'hF, INC, LIN, 32'hA1A1A1A1, 1, 0));
        tbl.push_back(w(32'hFFFC, 4'hF, INC, LIN, 32'hA2A2A2A2, 1, 0));
        tbl.push_back(w(32'h00010000, 4'hF, INC, LIN, 32'hEEEEEEEE, 0, 1));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'hFFF8, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'hFFF8, CL, LIN, 1, 0, 1, 32'hA1A1A1A1));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'hFFFC, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'hFFFC, CL, LIN, 1, 0, 1, 32'hA2A2A2A2));
        tbl.push_back(idle_v());
        tbl.push_back(r(32'h0, CL, LIN, 0, 0, 0, 32'h0));
        tbl.push_back(r(32'h0, CL, LIN, 1, 0, 1, 32'h12345678));
        tbl.push_back(idle_v());

        // Reset with a request pending: outputs must stay quiet
        rst = 1'b1;
        drive(w(32'h100, 4'hF, CL, LIN, 32'h0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ack", 32'(ack), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset rty", 32'(rty), 32'h0);
        @(posedge clk);
        #1;
        drive(idle_v());
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i]);
        end

        // Reset during beat 2 of a 4-beat write burst
        classic_wr(32'h300, 32'hC1C1C1C1);
        classic_wr(32'h304, 32'hC2C2C2C2);
        classic_wr(32'h308, 32'hC3C3C3C3);
        classic_wr(32'h30C, 32'hC4C4C4C4);
        run_row(w(32'h300, 4'hF, INC, LIN, 32'hB1B1B1B1, 0, 0));
        run_row(w(32'h300, 4'hF, INC, LIN, 32'hB1B1B1B1, 1, 0));
        drive(w(32'h304, 4'hF, INC, LIN, 32'hB2B2B2B2, 0, 0));
        #2;
        chk("beat2 ack before reset", 32'(ack), 32'h1);
        rst = 1'b1;
        #1;
        chk("beat2 ack at reset", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        drive(w(32'h308, 4'hF, INC, LIN, 32'hB3B3B3B3, 0, 0));
        @(negedge clk);
        chk("beat3 ack in reset", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        drive(w(32'h30C, 4'hF, EOB, LIN, 32'hB4B4B4B4, 0, 0));
        @(negedge clk);
        chk("beat4 ack in reset", 32'(ack), 32'h0);
        @(posedge clk);
        #1;
        drive(idle_v());
        rst = 1'b0;
        classic_rd(32'h300, 32'hB1B1B1B1);
        classic_rd(32'h308, 32'hC3C3C3C3);
        classic_rd(32'h30C, 32'hC4C4C4C4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
